// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: a pixel-clock divider feeding h/v counters,
// with every output taken from one register stage so sync, video_on and coordinates stay aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             tick;
  logic             h_wrap;
  logic             vid;
  logic             hs_on;
  logic             vs_on;

  // The divider only advances while enabled, so a freeze resumes mid-pixel without skipping.
  assign tick   = enable && (div == DIV_LAST);
  assign h_wrap = (h == H_LAST);
  assign vid    = (h < H_VIS) && (v < V_VIS);
  assign hs_on  = (h >= HS_FIRST) && (h <= HS_LAST);
  assign vs_on  = (v >= VS_FIRST) && (v <= VS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      p_tick      <= tick;
      line_start  <= tick && (h == '0);
      frame_start <= tick && (h == '0) && (v == '0);
      if (enable) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      // Outputs capture the decode of the counter value being left, then the counters move on.
      if (tick) begin
        pixel_x  <= h;
        pixel_y  <= v;
        video_on <= vid;
        hsync    <= hs_on ? H_POL : ~H_POL;
        vsync    <= vs_on ? V_POL : ~V_POL;
        h        <= h_wrap ? '0 : h + 1'b1;
        if (h_wrap) v <= (v == V_LAST) ? '0 : v + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default, a small CLK_DIV=3 one, and the
// tiny CLK_DIV=1 one) run side by side against an arithmetic raster model.
module tb_vga_timing_gen;
  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hpol, vpol;
    int d;
  } cfg_t;

  logic        clk;
  logic        rst         [3];
  logic        en          [3];
  logic        p_tick      [3];
  logic        hsync       [3];
  logic        vsync       [3];
  logic        video_on    [3];
  logic        line_start  [3];
  logic        frame_start [3];
  logic [10:0] px          [3];
  logic [10:0] py          [3];
  logic [27:0] obs         [3];

  cfg_t cfg [3];
  int   ecnt [3];
  bit   stb  [3];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  vga_timing_gen dut_def (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .p_tick(p_tick[0]), .hsync(hsync[0]),
    .vsync(vsync[0]), .video_on(video_on[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .line_start(line_start[0]), .frame_start(frame_start[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(2), .V_ACTIVE(10), .V_FP(2), .V_SYNC(2),
    .V_BP(3), .H_POL(1'b0), .V_POL(1'b1), .CLK_DIV(3), .CNT_W(11)
  ) dut_mid (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .p_tick(p_tick[1]), .hsync(hsync[1]),
    .vsync(vsync[1]), .video_on(video_on[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .line_start(line_start[1]), .frame_start(frame_start[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CNT_W(11)
  ) dut_sml (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .p_tick(p_tick[2]), .hsync(hsync[2]),
    .vsync(vsync[2]), .video_on(video_on[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .line_start(line_start[2]), .frame_start(frame_start[2])
  );

  assign obs[0] = {p_tick[0], hsync[0], vsync[0], video_on[0], line_start[0], frame_start[0], px[0], py[0]};
  assign obs[1] = {p_tick[1], hsync[1], vsync[1], video_on[1], line_start[1], frame_start[1], px[1], py[1]};
  assign obs[2] = {p_tick[2], hsync[2], vsync[2], video_on[2], line_start[2], frame_start[2], px[2], py[2]};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster model: after e enabled edges since reset, e/d pixels have been presented;
  // the last one is pixel number (e/d - 1) of the frame in raster order.
  function automatic logic [27:0] model(cfg_t c, int e, bit s);
    int   ht, vt, t, p, x, y;
    logic hs, vs, von, ls, fs;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    t  = e / c.d;
    if (t == 0) return {1'b0, ~c.hpol, ~c.vpol, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
    p   = (t - 1) % (ht * vt);
    x   = p % ht;
    y   = p / ht;
    von = (x < c.ha) && (y < c.va);
    hs  = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
    vs  = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
    ls  = s && (x == 0);
    fs  = ls && (y == 0);
    return {s, hs, vs, von, ls, fs, 11'(x), 11'(y)};
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Driver: one clock edge, update the model's view of the edge, then compare all DUTs.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        ecnt[i] = 0;
        stb[i]  = 1'b0;
      end else if (en[i]) begin
        ecnt[i]++;
        stb[i] = (ecnt[i] % cfg[i].d) == 0;
      end else begin
        stb[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("model_dut%0d", i), 32'(obs[i]), 32'(model(cfg[i], ecnt[i], stb[i])));
  endtask

  initial begin
    int  def_last_ls = -1;
    bit  def_prev_hs = 1'b1;
    int  hs_run      = 0;
    int  mid_last_fs = -1;
    bit  mid_froze   = 1'b0;
    bit  mid_frz_done = 1'b0;
    bit  mid_wait_next = 1'b0;
    int  frz_left    = 0;
    int  sml_state   = 0;
    bit  sml_at_last = 1'b0;
    int  n_wrap      = 0;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
    cfg[1] = '{20, 3, 4, 2, 10, 2, 2, 3, 1'b0, 1'b1, 3};
    cfg[2] = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 1};
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      en[i]   = 1'b1;
      ecnt[i] = 0;
      stb[i]  = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    for (int k = 0; k < 3400; k++) begin
      step();
      if (k == 0) check("def_release_edge1", 32'({p_tick[0], video_on[0], px[0], py[0]}), 32'd0);
      if (k == 1) check("def_release_edge2",
                        32'({px[0], py[0], video_on[0], p_tick[0], line_start[0], frame_start[0]}),
                        32'({11'd0, 11'd0, 4'hf}));

      if (line_start[0]) begin
        if (def_last_ls >= 0) check("def_line_period", 32'(cyc - def_last_ls), 32'd1600);
        def_last_ls = cyc;
      end
      if (def_prev_hs && !hsync[0]) begin
        check("def_hsync_start_x", 32'(px[0]), 32'd656);
        hs_run = 1;
      end else if (!hsync[0]) begin
        hs_run++;
      end
      if (!def_prev_hs && hsync[0]) check("def_hsync_width", 32'(hs_run), 32'd192);
      def_prev_hs = hsync[0];

      if (frame_start[1]) begin
        if (mid_last_fs >= 0)
          check("mid_frame_period", 32'(cyc - mid_last_fs), mid_froze ? 32'd1516 : 32'd1479);
        mid_last_fs = cyc;
        mid_froze   = 1'b0;
      end
      if (mid_wait_next && p_tick[1]) begin
        check("mid_resume_pixel", 32'({px[1], py[1]}), 32'({11'd11, 11'd5}));
        mid_wait_next = 1'b0;
      end
      if (!mid_frz_done && p_tick[1] && px[1] == 11'd10 && py[1] == 11'd5) begin
        en[1]        = 1'b0;
        frz_left     = 37;
        mid_frz_done = 1'b1;
        mid_froze    = 1'b1;
      end else if (frz_left > 0) begin
        check("mid_freeze_hold", 32'({p_tick[1], line_start[1], frame_start[1], px[1], py[1]}),
              32'({3'b000, 11'd10, 11'd5}));
        frz_left--;
        if (frz_left == 0) begin
          en[1]         = 1'b1;
          mid_wait_next = 1'b1;
        end
      end

      if (p_tick[2]) begin
        if (sml_at_last) begin
          check("sml_wrap_corner", 32'({frame_start[2], line_start[2], px[2], py[2]}),
                32'({2'b11, 11'd0, 11'd0}));
          n_wrap++;
        end
        sml_at_last = (px[2] == 11'd13) && (py[2] == 11'd7);
      end
      if (sml_state == 1) begin
        check("sml_reset_values", 32'(obs[2]), 32'd0);
        rst[2]    = 1'b0;
        sml_state = 2;
      end else if (sml_state == 2 && p_tick[2]) begin
        check("sml_restart", 32'({frame_start[2], line_start[2], px[2], py[2]}),
              32'({2'b11, 11'd0, 11'd0}));
        sml_state = 3;
      end else if (sml_state == 0 && k >= 800 && p_tick[2] && px[2] == 11'd9 && py[2] == 11'd3) begin
        rst[2]    = 1'b1;
        sml_state = 1;
      end
      en[2] = (k < 1500) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    check("sml_wrap_seen", 32'(n_wrap > 0), 32'd1);
    check("sml_reset_seen", 32'(sml_state), 32'd3);

    // Reset while disabled still clears everything; restart presents (0,0) on edge 2.
    rst[0] = 1'b1;
    en[0]  = 1'b0;
    step();
    check("def_reset_while_frozen", 32'(obs[0]), 32'h600_0000);
    rst[0] = 1'b0;
    en[0]  = 1'b1;
    repeat (2) step();
    check("def_restart_frame", 32'({frame_start[0], line_start[0], px[0], py[0]}),
          32'({2'b11, 11'd0, 11'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
